// File: rtl/mac_relu_unit.sv
// Signed multiply-accumulate with ReLU output: a multiply register feeds an accumulate register,
// and a combinational ReLU is applied to the accumulator.
module mac_relu_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_acc,
    output logic signed [DATA_W-1:0] o_relu_acc,
    output logic                     o_busy
);

    logic signed [2*DATA_W-1:0] w_a_ext;
    logic signed [2*DATA_W-1:0] w_b_ext;
    logic signed [2*DATA_W-1:0] w_prod_full;
    logic signed [DATA_W-1:0]   w_prod_trunc;

    logic signed [DATA_W-1:0]   r_prod;
    logic                       r_prod_v;
    logic signed [DATA_W-1:0]   r_acc;

    // Full-width signed product, then keep the low DATA_W bits.
    assign w_a_ext      = {{DATA_W{i_a[DATA_W-1]}}, i_a};
    assign w_b_ext      = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    assign w_prod_full  = w_a_ext * w_b_ext;
    assign w_prod_trunc = w_prod_full[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod   <= '0;
            r_prod_v <= 1'b0;
        end else begin
            r_prod_v <= i_enable;
            if (i_enable) begin
                r_prod <= w_prod_trunc;
            end
        end
    end

    // Wrap-around accumulation; no saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_prod_v) begin
            r_acc <= r_acc + r_prod;
        end
    end

    always_comb begin
        o_acc      = r_acc;
        o_busy     = r_prod_v;
        o_relu_acc = r_acc[DATA_W-1] ? '0 : r_acc;
    end

endmodule

// File: tb/tb_mac_relu_unit.sv
// Directed bench for mac_relu_unit: dot product, sign, latency, gaps, reset and wrap-around.
module tb_mac_relu_unit;

    localparam int unsigned DATA_W = 32;

    logic                     clk;
    logic                     rst;
    logic                     i_enable;
    logic signed [DATA_W-1:0] i_a;
    logic signed [DATA_W-1:0] i_b;
    logic signed [DATA_W-1:0] o_acc;
    logic signed [DATA_W-1:0] o_relu_acc;
    logic                     o_busy;

    int checks = 0;
    int errors = 0;

    mac_relu_unit #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_acc      (o_acc),
        .o_relu_acc (o_relu_acc),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consume one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_enable = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
        i_a      = a;
        i_b      = b;
        i_enable = 1'b1;
        tick();
        i_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        i_enable = 1'b1;
        i_a      = 32'sd3;
        i_b      = 32'sd3;
        tick();
        tick();
        do_reset();
        checks++;
        if (o_acc !== 32'sd0) begin
            errors++;
            $display("FAIL reset_acc: got %0d expected 0", o_acc);
        end
        checks++;
        if (o_relu_acc !== 32'sd0) begin
            errors++;
            $display("FAIL reset_relu: got %0d expected 0", o_relu_acc);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b expected 0", o_busy);
        end
    endtask

    task automatic test_kernel();
        int ka[9] = '{10, 20, 30, 1, 2, 3, 40, 50, 60};
        int kb[9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            i_a      = ka[i];
            i_b      = kb[i];
            i_enable = 1'b1;
            tick();
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL kernel_busy[%0d]: got %0b expected 1", i, o_busy);
            end
        end
        i_enable = 1'b0;
        tick();
        checks++;
        if (o_acc !== 32'sd90) begin
            errors++;
            $display("FAIL kernel_acc: got %0d expected 90", o_acc);
        end
        checks++;
        if (o_relu_acc !== 32'sd90) begin
            errors++;
            $display("FAIL kernel_relu: got %0d expected 90", o_relu_acc);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL kernel_busy_drained: got %0b expected 0", o_busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_acc !== 32'sd90) begin
                errors++;
                $display("FAIL kernel_hold[%0d]: got %0d expected 90", i, o_acc);
            end
        end
    endtask

    task automatic test_negative();
        do_reset();
        push(32'sd5, -32'sd3);
        tick();
        checks++;
        if (o_acc !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL neg_acc: got %08h expected fffffff1", o_acc);
        end
        checks++;
        if (o_relu_acc !== 32'sd0) begin
            errors++;
            $display("FAIL neg_relu: got %0d expected 0", o_relu_acc);
        end
        push(32'sd4, 32'sd4);
        tick();
        checks++;
        if (o_acc !== 32'sd1) begin
            errors++;
            $display("FAIL neg_recover_acc: got %0d expected 1", o_acc);
        end
        checks++;
        if (o_relu_acc !== 32'sd1) begin
            errors++;
            $display("FAIL neg_recover_relu: got %0d expected 1", o_relu_acc);
        end
    endtask

    task automatic test_latency();
        do_reset();
        push(32'sd7, 32'sd6);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL lat_busy_e0: got %0b expected 1", o_busy);
        end
        checks++;
        if (o_acc !== 32'sd0) begin
            errors++;
            $display("FAIL lat_acc_e0: got %0d expected 0", o_acc);
        end
        tick();
        checks++;
        if (o_acc !== 32'sd42) begin
            errors++;
            $display("FAIL lat_acc_e1: got %0d expected 42", o_acc);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_busy_e1: got %0b expected 0", o_busy);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        push(32'sd2, 32'sd3);
        tick();
        checks++;
        if (o_acc !== 32'sd6) begin
            errors++;
            $display("FAIL gap_acc_first: got %0d expected 6", o_acc);
        end
        // Garbage operands while idle must not disturb the accumulator.
        for (int i = 0; i < 2; i++) begin
            i_a = $urandom;
            i_b = $urandom;
            tick();
            checks++;
            if (o_acc !== 32'sd6) begin
                errors++;
                $display("FAIL gap_idle[%0d]: got %0d expected 6", i, o_acc);
            end
        end
        push(32'sd4, 32'sd5);
        i_a = $urandom;
        i_b = $urandom;
        tick();
        checks++;
        if (o_acc !== 32'sd26) begin
            errors++;
            $display("FAIL gap_acc_second: got %0d expected 26", o_acc);
        end
        push(-32'sd1, 32'sd1);
        tick();
        checks++;
        if (o_acc !== 32'sd25) begin
            errors++;
            $display("FAIL gap_acc_final: got %0d expected 25", o_acc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(32'sd10, 32'sd10);
        tick();
        checks++;
        if (o_acc !== 32'sd100) begin
            errors++;
            $display("FAIL rmid_pre: got %0d expected 100", o_acc);
        end
        push(32'sd1, 32'sd1);
        i_a      = 32'sd9;
        i_b      = 32'sd9;
        i_enable = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        i_enable = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_busy_edge: got %0b expected 0", o_busy);
        end
        tick();
        checks++;
        if (o_acc !== 32'sd0) begin
            errors++;
            $display("FAIL rmid_acc: got %0d expected 0", o_acc);
        end
        checks++;
        if (o_relu_acc !== 32'sd0) begin
            errors++;
            $display("FAIL rmid_relu: got %0d expected 0", o_relu_acc);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_busy: got %0b expected 0", o_busy);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push(32'sh7FFF_FFFF, 32'sd1);
        push(32'sd1, 32'sd1);
        tick();
        checks++;
        if (o_acc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ovf_acc: got %08h expected 80000000", o_acc);
        end
        checks++;
        if (o_relu_acc !== 32'sd0) begin
            errors++;
            $display("FAIL ovf_relu: got %08h expected 00000000", o_relu_acc);
        end
        push(32'sh0001_0000, 32'sh0001_0000);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL trunc_busy: got %0b expected 1", o_busy);
        end
        tick();
        checks++;
        if (o_acc !== 32'h8000_0000) begin
            errors++;
            $display("FAIL trunc_acc: got %08h expected 80000000", o_acc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            i_a = i;
            i_b = 32'sd2;
            tick();
        end
        // Three of four products landed so far: 2+4+6.
        checks++;
        if (o_acc !== 32'sd12) begin
            errors++;
            $display("FAIL b2b_partial: got %0d expected 12", o_acc);
        end
        i_enable = 1'b0;
        tick();
        checks++;
        if (o_acc !== 32'sd20) begin
            errors++;
            $display("FAIL b2b_final: got %0d expected 20", o_acc);
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_enable = 1'b0;
        i_a      = '0;
        i_b      = '0;
        test_reset();
        test_kernel();
        test_negative();
        test_latency();
        test_gaps();
        test_reset_mid();
        test_overflow();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_relu_unit.md
Name: mac_relu_unit

Overview:
- Signed multiply-accumulate datapath with ReLU activation on the accumulator.
- Used by the CNN convolution engine to compute one 3x3 kernel dot product per output pixel.
- The engine streams nine (pixel, weight) pairs, waits for the pipeline to drain, then reads the rectified sum.
- Two-stage pipeline (multiply register, accumulate register) followed by a combinational ReLU.

Parameters:
- DATA_W, 32, width of operands a/b, accumulator and ReLU output.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; clears accumulator and pipeline.
- enable  input  1  high = a/b sampled this edge as a valid product term.
- a  input  DATA_W  signed operand (pixel value).
- b  input  DATA_W  signed operand (kernel weight).
- acc  output  DATA_W  signed running accumulator, registered.
- relu_acc  output  DATA_W  ReLU of acc, combinational from acc.
- busy  output  1  high while a sampled product has not yet been added to acc.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk.
  - At a rising edge with rst=1: prod_r=0, prod_v=0, acc=0.
  - Hence relu_acc=0 and busy=0.
  - rst has priority over enable. An operand pair presented with enable during a reset edge is discarded.
  - An in-flight product is discarded (reset mid-operation loses all partial sums).
- Stage 1 (multiply), at each edge without rst:
  - prod_v <= enable.
  - If enable, prod_r <= a*b, computed as a full 2*DATA_W signed product, then truncated to the low DATA_W bits.
  - If enable=0, prod_r holds its value; it is unused because prod_v=0.
- Stage 2 (accumulate), at each edge without rst:
  - If prod_v, acc <= acc + prod_r, two's-complement wrap-around on overflow, no saturation.
  - Otherwise acc holds.
- Latency: a pair sampled at edge E0 is reflected in acc after edge E0+1 (2-edge latency).
  - Back-to-back enable accepts one pair per cycle, full throughput.
- Drain: deasserting enable does not cancel an in-flight product. The last pair, sampled at edge E, is still accumulated at E+1.
- busy = prod_v (combinational from register).
- ReLU: relu_acc = acc when acc[DATA_W-1]=0, else 0. Purely combinational, no extra latency.
- Enable gaps: enable may drop for any number of cycles mid-sequence; acc holds and resumes accumulation when enable returns.
- No auto-clear: the next dot product requires a rst pulse. The caller issues rst between output pixels.
- No X propagation from a/b when enable=0: unused operands must not affect acc.
- Operand widths: a and b are treated as signed in all arithmetic.

Test Plan:
- Kernel dot product:
  - Stimulus: rst 1 cycle, then 9 consecutive enabled pairs: a=10,20,30 with b=-1; a=1,2,3 with b=0; a=40,50,60 with b=1; then enable=0.
  - Response: two edges after the last pair, acc=90, relu_acc=90, busy=0. acc holds 90 for 5 further idle cycles.
- Negative sum:
  - Stimulus: after rst, one pair a=5, b=-3.
  - Response: acc=-15 (0xFFFFFFF1), relu_acc=0. A subsequent a=4, b=4 gives acc=1, relu_acc=1.
- Latency and busy:
  - Stimulus: single pair a=7, b=6 at edge E0.
  - Response: busy=1 between E0 and E0+1, acc=0 before E0+1, acc=42 after E0+1, busy=0.
- Enable gaps:
  - Stimulus: pairs (2,3), idle 3 cycles, (4,5), idle 1 cycle, (-1,1).
  - Response: final acc=25. acc never changes during idle cycles except the single drain edge.
- Reset mid-operation:
  - Stimulus: accumulate 100, present a=9, b=9 with enable=1 and rst=1 on the same edge, then 1 idle cycle.
  - Response: acc=0, relu_acc=0, busy=0. The 81 is never added.
- Overflow wrap:
  - Stimulus: after rst, a=0x7FFFFFFF, b=1, then a=1, b=1.
  - Response: acc=0x80000000 (negative), relu_acc=0.
  - Also a=0x10000, b=0x10000 yields a product truncated to 0, so acc is unchanged.
